// File: rtl/tohost_monitor.sv
// Watches the core's tohost word, declares PASS/FAIL once a nonzero value holds steady,
// and drives a registered display word plus status LEDs. Optional macro: TOHOST_MONITOR_TIMEOUT_EN.
module tohost_monitor #(
  parameter int unsigned STABLE_CYCLES  = 2,
  parameter int unsigned HB_SHIFT       = 24,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] tohost,
  input  logic        sel,
  output logic [31:0] disp,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic        heartbeat
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PASS = 2'd2;
  localparam logic [1:0] S_FAIL = 2'd3;

  localparam logic [31:0] STAB_LAST = 32'(STABLE_CYCLES - 1);
  localparam logic [HB_SHIFT:0] HB_ONE = {{HB_SHIFT{1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [31:0]       cyc_cnt_q, cyc_cnt_d;
  logic [31:0]       stab_cnt_q, stab_cnt_d;
  logic [31:0]       res_q, res_d;
  logic [31:0]       prev_q, prev_d;
  logic [31:0]       disp_q, disp_d;
  logic [HB_SHIFT:0] hb_cnt_q, hb_cnt_d;
  logic [31:0]       stab_next;
  logic              stable_hit;
  logic              terminal;
`ifdef TOHOST_MONITOR_TIMEOUT_EN
  logic              timeout_q, timeout_d;
`endif

  assign terminal = (state_q == S_PASS) || (state_q == S_FAIL);

  // A first nonzero cycle (no match with prev) yields run length 0, so STABLE_CYCLES=1 ends at once.
  always_comb begin
    stab_next  = ((tohost != 32'd0) && (tohost == prev_q)) ? stab_cnt_q + 32'd1 : 32'd0;
    stable_hit = (tohost != 32'd0) && (stab_next == STAB_LAST);
  end

  always_comb begin
    state_d    = state_q;
    cyc_cnt_d  = cyc_cnt_q;
    stab_cnt_d = stab_cnt_q;
    res_d      = res_q;
    prev_d     = 32'd0;
    hb_cnt_d   = hb_cnt_q + HB_ONE;
`ifdef TOHOST_MONITOR_TIMEOUT_EN
    timeout_d  = timeout_q;
`endif
    case (state_q)
      S_IDLE: state_d = S_RUN;
      S_RUN: begin
        prev_d     = tohost;
        stab_cnt_d = stab_next;
        if (cyc_cnt_q != 32'hFFFF_FFFF) cyc_cnt_d = cyc_cnt_q + 32'd1;
        if (stable_hit) begin
          res_d   = tohost;
          state_d = (tohost == 32'h1) ? S_PASS : S_FAIL;
        end
`ifdef TOHOST_MONITOR_TIMEOUT_EN
        else if (cyc_cnt_q == TIMEOUT_CYCLES - 32'd1) begin
          res_d     = 32'hDEAD_0000;
          timeout_d = 1'b1;
          state_d   = S_FAIL;
        end
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    if (sel)           disp_d = cyc_cnt_q;
    else if (terminal) disp_d = res_q;
    else               disp_d = tohost;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      cyc_cnt_q  <= 32'd0;
      stab_cnt_q <= 32'd0;
      res_q      <= 32'd0;
      prev_q     <= 32'd0;
      disp_q     <= 32'd0;
      hb_cnt_q   <= '0;
`ifdef TOHOST_MONITOR_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cyc_cnt_q  <= cyc_cnt_d;
      stab_cnt_q <= stab_cnt_d;
      res_q      <= res_d;
      prev_q     <= prev_d;
      disp_q     <= disp_d;
      hb_cnt_q   <= hb_cnt_d;
`ifdef TOHOST_MONITOR_TIMEOUT_EN
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign disp = disp_q;
  assign done = terminal;
  assign pass = (state_q == S_PASS);
  assign fail = (state_q == S_FAIL);
`ifdef TOHOST_MONITOR_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    case (state_q)
      S_RUN:   heartbeat = hb_cnt_q[HB_SHIFT];
      S_PASS:  heartbeat = 1'b1;
      default: heartbeat = 1'b0;
    endcase
  end

endmodule
